// File: rtl/wb_arbiter_2x1.sv
// wb_arbiter_2x1 -- two-master to one-slave Wishbone (pipelined) arbiter that
// keeps exactly one transaction outstanding downstream.
//
// Ports
//   CLK, RSTN                  clock, synchronous active-low reset
//   M_CYC/M_STB/M_WE [1:0]     per-master request qualifiers (bit i = master i)
//   M_ADDR/M_WDATA/M_SEL       packed per-master request fields (slice i = master i)
//   M_STALL/M_ACK/M_ERR [1:0]  per-master stall and registered response pulses
//   M_RDATA                    shared read data, valid only with M_ACK
//   S_CYC/S_STB/S_WE/S_ADDR/S_WDATA/S_SEL   downstream request (fields registered)
//   S_STALL/S_ACK/S_ERR/S_RDATA             downstream response
//
// Build option
//   WB_ARB_TIMEOUT_EN  adds a watchdog: after TIMEOUT_CYCLES busy cycles with no
//                      downstream response the granted master gets an M_ERR pulse
//                      and the arbiter returns to IDLE.

module wb_arbiter_2x1 #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      CLK,
    input  logic                      RSTN,
    input  logic [1:0]                M_CYC,
    input  logic [1:0]                M_STB,
    input  logic [1:0]                M_WE,
    input  logic [2*ADDR_WIDTH-1:0]   M_ADDR,
    input  logic [2*DATA_WIDTH-1:0]   M_WDATA,
    input  logic [2*DATA_WIDTH/8-1:0] M_SEL,
    output logic [1:0]                M_STALL,
    output logic [1:0]                M_ACK,
    output logic [1:0]                M_ERR,
    output logic [DATA_WIDTH-1:0]     M_RDATA,
    output logic                      S_CYC,
    output logic                      S_STB,
    output logic                      S_WE,
    output logic [ADDR_WIDTH-1:0]     S_ADDR,
    output logic [DATA_WIDTH-1:0]     S_WDATA,
    output logic [DATA_WIDTH/8-1:0]   S_SEL,
    input  logic                      S_STALL,
    input  logic                      S_ACK,
    input  logic                      S_ERR,
    input  logic [DATA_WIDTH-1:0]     S_RDATA
);

    localparam int SW = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

    state_t                state_q, state_d;
    logic                  ptr_q, ptr_d;       // master served last
    logic                  grant_q, grant_d;
    logic                  abort_q, abort_d;   // granted master dropped CYC mid-transaction
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SW-1:0]         sel_q, sel_d;
    logic [1:0]            ack_q, ack_d;
    logic [1:0]            err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic [1:0] req;
    logic       win_vld;
    logic       win;
    logic       resp;
    logic       timeout;

    assign req     = M_CYC & M_STB;
    assign win_vld = |req;
    // Tie goes to the master not served last; otherwise the sole requester.
    assign win     = (req == 2'b11) ? ~ptr_q : req[1];

    // A response only counts once the strobe has been taken (not while stalled).
    assign resp = (S_ACK || S_ERR) &&
                  ((state_q == ISSUE && !S_STALL) || state_q == WAIT);

`ifdef WB_ARB_TIMEOUT_EN
    logic [15:0] cnt_q, cnt_d;

    // Held at zero in IDLE, so it starts from zero on every acceptance.
    always_comb begin
        cnt_d = '0;
        if (state_q != IDLE) cnt_d = cnt_q + 16'd1;
    end

    // Fires in the busy cycle that brings the count to TIMEOUT_CYCLES.
    assign timeout = (state_q != IDLE) && !resp &&
                     (({1'b0, cnt_q} + 17'd1) == 17'(TIMEOUT_CYCLES));

    always_ff @(posedge CLK) begin
        if (!RSTN) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
`else
    logic cfg_unused;
    assign cfg_unused = (TIMEOUT_CYCLES != 0);
    assign timeout    = 1'b0;
`endif

    always_comb begin
        M_STALL = 2'b11;
        if (state_q == IDLE && win_vld) M_STALL[win] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        abort_d = abort_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        sel_d   = sel_q;
        ack_d   = 2'b00;
        err_d   = 2'b00;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    state_d = ISSUE;
                    grant_d = win;
                    abort_d = 1'b0;
                    we_d    = M_WE[win];
                    addr_d  = win ? M_ADDR[2*ADDR_WIDTH-1:ADDR_WIDTH] : M_ADDR[ADDR_WIDTH-1:0];
                    wdata_d = win ? M_WDATA[2*DATA_WIDTH-1:DATA_WIDTH] : M_WDATA[DATA_WIDTH-1:0];
                    sel_d   = win ? M_SEL[2*SW-1:SW] : M_SEL[SW-1:0];
                end
            end
            ISSUE, WAIT: begin
                abort_d = abort_q || !M_CYC[grant_q];
                if (resp) begin
                    state_d = IDLE;
                    ptr_d   = grant_q;
                    rdata_d = S_RDATA;
                    if (!abort_d) begin
                        ack_d[grant_q] = S_ACK;
                        err_d[grant_q] = S_ERR;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    ptr_d   = grant_q;
                    if (!abort_d) err_d[grant_q] = 1'b1;
                end else if (state_q == ISSUE && !S_STALL) begin
                    state_d = WAIT;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            state_q <= IDLE;
            ptr_q   <= 1'b1;
            grant_q <= 1'b0;
            abort_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            sel_q   <= '0;
            ack_q   <= 2'b00;
            err_q   <= 2'b00;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            abort_q <= abort_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            sel_q   <= sel_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end

    assign S_CYC   = (state_q != IDLE);
    assign S_STB   = (state_q == ISSUE);
    assign S_WE    = we_q;
    assign S_ADDR  = addr_q;
    assign S_WDATA = wdata_q;
    assign S_SEL   = sel_q;
    assign M_ACK   = ack_q;
    assign M_ERR   = err_q;
    assign M_RDATA = rdata_q;

endmodule

// File: tb/tb_wb_arbiter_2x1.sv
// tb_wb_arbiter_2x1 -- self-checking bench for wb_arbiter_2x1: a reset-time
// stall table, directed multi-cycle sequences, and a randomized run checked
// against a transaction-level reference model. Set WB_ARB_TIMEOUT_EN to
// include the watchdog sequence (TIMEOUT_CYCLES = 8).

module tb_wb_arbiter_2x1;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int T  = 8;

    logic          CLK = 1'b0;
    logic          RSTN;
    logic [1:0]    m_cyc, m_stb, m_we;
    logic [2*AW-1:0] m_addr;
    logic [2*DW-1:0] m_wdata;
    logic [7:0]    m_sel;
    logic [1:0]    M_STALL, M_ACK, M_ERR;
    logic [DW-1:0] M_RDATA;
    logic          S_CYC, S_STB, S_WE;
    logic [AW-1:0] S_ADDR;
    logic [DW-1:0] S_WDATA;
    logic [3:0]    S_SEL;
    logic          s_stall, s_ack, s_err;
    logic [DW-1:0] s_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    wb_arbiter_2x1 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T)) dut (
        .CLK(CLK), .RSTN(RSTN),
        .M_CYC(m_cyc), .M_STB(m_stb), .M_WE(m_we),
        .M_ADDR(m_addr), .M_WDATA(m_wdata), .M_SEL(m_sel),
        .M_STALL(M_STALL), .M_ACK(M_ACK), .M_ERR(M_ERR), .M_RDATA(M_RDATA),
        .S_CYC(S_CYC), .S_STB(S_STB), .S_WE(S_WE),
        .S_ADDR(S_ADDR), .S_WDATA(S_WDATA), .S_SEL(S_SEL),
        .S_STALL(s_stall), .S_ACK(s_ack), .S_ERR(s_err), .S_RDATA(s_rdata)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_all();
        m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
        m_addr = '0; m_wdata = '0; m_sel = '0;
        s_stall = 1'b0; s_ack = 1'b0; s_err = 1'b0; s_rdata = '0;
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        idle_all();
        tick();
        tick();
        RSTN = 1'b1;
    endtask

    task automatic set_req(input int i, input logic we, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        m_cyc[i] = 1'b1;
        m_stb[i] = 1'b1;
        m_we[i]  = we;
        m_addr[i*32 +: 32]  = a;
        m_wdata[i*32 +: 32] = d;
        m_sel[i*4 +: 4]     = s;
    endtask

    typedef struct {
        logic [1:0] cyc;
        logic [1:0] stb;
        logic [1:0] stall;
    } vec_t;

    vec_t tbl[8];

    // reference-model state for the random run
    int          mst[2];          // 0 idle, 1 requesting, 2 waiting for response
    logic [31:0] ra[2], rd[2];
    logic [3:0]  rs[2];
    logic        rw[2];
    bit          busy, stb_ph;
    int          g, last, cnt;
    logic [1:0]  exp_ack, exp_err;
    logic [31:0] exp_rd;

    initial begin
        // With reset held the arbiter sits in IDLE with pointer 1.
        tbl[0] = '{cyc: 2'b00, stb: 2'b00, stall: 2'b11};
        tbl[1] = '{cyc: 2'b01, stb: 2'b01, stall: 2'b10};
        tbl[2] = '{cyc: 2'b10, stb: 2'b10, stall: 2'b01};
        tbl[3] = '{cyc: 2'b11, stb: 2'b11, stall: 2'b10};
        tbl[4] = '{cyc: 2'b11, stb: 2'b01, stall: 2'b10};
        tbl[5] = '{cyc: 2'b11, stb: 2'b10, stall: 2'b01};
        tbl[6] = '{cyc: 2'b01, stb: 2'b00, stall: 2'b11};
        tbl[7] = '{cyc: 2'b10, stb: 2'b11, stall: 2'b01};

        RSTN = 1'b0;
        idle_all();
        tick();
        tick();
        chk("rst_s_cyc", S_CYC, 0);
        chk("rst_s_stb", S_STB, 0);
        chk("rst_s_we", S_WE, 0);
        chk("rst_s_addr", S_ADDR, 0);
        chk("rst_s_wdata", S_WDATA, 0);
        chk("rst_s_sel", S_SEL, 0);
        chk("rst_m_ack", M_ACK, 0);
        chk("rst_m_err", M_ERR, 0);
        chk("rst_m_rdata", M_RDATA, 0);
        for (int k = 0; k < 8; k++) begin
            m_cyc = tbl[k].cyc;
            m_stb = tbl[k].stb;
            #2;
            chk($sformatf("tbl_stall[%0d]", k), M_STALL, tbl[k].stall);
        end
        tick();
        chk("rst_hold_s_cyc", S_CYC, 0);
        idle_all();
        RSTN = 1'b1;
        tick();

        // A: single write, ack three cycles after the strobe cycle
        set_req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        #1 chk("A_stall", M_STALL, 2'b10);
        tick();
        m_stb = 2'b00;
        chk("A_s_stb", S_STB, 1);
        chk("A_s_addr", S_ADDR, 32'h10);
        chk("A_s_wdata", S_WDATA, 32'hDEADBEEF);
        chk("A_s_sel", S_SEL, 4'hF);
        chk("A_s_we", S_WE, 1);
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("A_stb_once", S_STB, 0);
            chk("A_no_early_ack", M_ACK, 0);
            if (k == 3) s_ack = 1'b1;
        end
        tick();
        s_ack = 1'b0;
        chk("A_ack", M_ACK, 2'b01);
        chk("A_err", M_ERR, 0);
        chk("A_idle", S_CYC, 0);
        tick();
        chk("A_ack_pulse", M_ACK, 0);
        m_cyc = 2'b00;

        // B: simultaneous reads after reset, master 0 first
        do_reset();
        set_req(0, 1'b0, 32'h100, 32'h0, 4'hF);
        set_req(1, 1'b0, 32'h200, 32'h0, 4'hF);
        #1 chk("B_stall_first", M_STALL, 2'b10);
        tick();
        m_stb[0] = 1'b0;
        chk("B_addr0", S_ADDR, 32'h100);
        chk("B_stall_busy", M_STALL, 2'b11);
        s_ack = 1'b1; s_rdata = 32'h11111111;
        tick();
        s_ack = 1'b0; s_rdata = '0;
        chk("B_ack0", M_ACK, 2'b01);
        chk("B_rdata0", M_RDATA, 32'h11111111);
        chk("B_stall_second", M_STALL, 2'b01);
        m_cyc[0] = 1'b0;
        tick();
        m_stb[1] = 1'b0;
        chk("B_addr1", S_ADDR, 32'h200);
        s_ack = 1'b1; s_rdata = 32'h22222222;
        tick();
        s_ack = 1'b0;
        chk("B_ack1", M_ACK, 2'b10);
        chk("B_rdata1", M_RDATA, 32'h22222222);
        m_cyc = 2'b00;
        tick();

        // C: both masters request continuously, grants alternate
        begin
            int ngr = 0;
            int nstb = 0;
            set_req(0, 1'b0, 32'h30, 0, 4'h1);
            set_req(1, 1'b0, 32'h34, 0, 4'h2);
            s_ack = 1'b1;
            for (int k = 0; k < 40 && ngr < 6; k++) begin
                tick();
                if (S_STB) nstb++;
                if (M_ACK == 2'b01 || M_ACK == 2'b10) begin
                    chk($sformatf("C_grant[%0d]", ngr), M_ACK[1], ngr % 2);
                    ngr++;
                end
                if (ngr == 6) begin
                    m_cyc = 2'b00; m_stb = 2'b00; s_ack = 1'b0;
                end
            end
            chk("C_count", ngr, 6);
            chk("C_stb_cycles", nstb, 6);
            idle_all();
            tick();
        end

        // D: downstream stall held in ISSUE
        set_req(0, 1'b0, 32'h44, 0, 4'hF);
        #1 chk("D_accept", M_STALL, 2'b10);
        tick();
        m_stb = 2'b00;
        s_stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("D_stb_held", S_STB, 1);
            chk("D_addr_held", S_ADDR, 32'h44);
            s_ack = (k == 1);   // ack while stalled must be ignored
            if (k < 3) tick();
        end
        tick();
        s_stall = 1'b0;
        chk("D_stb_release", S_STB, 1);
        chk("D_stalled_ack_ignored", M_ACK, 0);
        tick();
        chk("D_wait_stb", S_STB, 0);
        chk("D_wait_cyc", S_CYC, 1);
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        chk("D_ack", M_ACK, 2'b01);
        m_cyc = 2'b00;
        tick();

        // E: spurious ack in IDLE, master abandons in WAIT, then an error response
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        chk("E_idle_ack", M_ACK, 0);
        chk("E_idle_cyc", S_CYC, 0);
        set_req(0, 1'b0, 32'h50, 0, 4'hF);
        tick();
        m_stb = 2'b00;
        tick();
        m_cyc = 2'b00;
        tick();
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        chk("E_abort_ack", M_ACK, 0);
        chk("E_abort_err", M_ERR, 0);
        chk("E_abort_idle", S_CYC, 0);
        set_req(1, 1'b1, 32'h60, 32'h5, 4'h3);
        #1 chk("E_next_accept", M_STALL, 2'b01);
        tick();
        m_stb = 2'b00;
        s_err = 1'b1;
        tick();
        s_err = 1'b0;
        chk("E_err", M_ERR, 2'b10);
        chk("E_err_no_ack", M_ACK, 0);
        m_cyc = 2'b00;
        tick();

`ifdef WB_ARB_TIMEOUT_EN
        // F: watchdog expiry, late ack dropped, next request served
        set_req(0, 1'b0, 32'h70, 0, 4'hF);
        #1 chk("F_accept", M_STALL, 2'b10);
        tick();
        m_stb = 2'b00;
        for (int k = 2; k <= T; k++) begin
            tick();
            chk("F_no_early_err", M_ERR, 0);
        end
        tick();
        chk("F_timeout_err", M_ERR, 2'b01);
        chk("F_timeout_ack", M_ACK, 0);
        chk("F_timeout_idle", S_CYC, 0);
        m_cyc = 2'b00;
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        chk("F_late_ack", M_ACK, 0);
        set_req(0, 1'b0, 32'h74, 0, 4'hF);
        #1 chk("F_reaccept", M_STALL, 2'b10);
        tick();
        m_stb = 2'b00;
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        chk("F_ack", M_ACK, 2'b01);
        m_cyc = 2'b00;
        tick();
`endif

        // Random run against the transaction-level model
        do_reset();
        mst[0] = 0; mst[1] = 0;
        busy = 0; stb_ph = 0; g = 0; last = 1; cnt = 0;
        exp_ack = 0; exp_err = 0; exp_rd = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            // registered responses from the previous edge
            chk("R_ack", M_ACK, exp_ack);
            chk("R_err", M_ERR, exp_err);
            if (exp_ack != 0) chk("R_rdata", M_RDATA, exp_rd);
            exp_ack = 0; exp_err = 0;

            for (int i = 0; i < 2; i++) begin
                if (mst[i] == 0 && ($urandom % 2) == 1) begin
                    mst[i] = 1;
                    ra[i] = $urandom; rd[i] = $urandom;
                    rs[i] = 4'($urandom_range(0, 15)); rw[i] = 1'($urandom % 2);
                    set_req(i, rw[i], ra[i], rd[i], rs[i]);
                end else if (mst[i] == 2) begin
                    m_cyc[i] = 1'b1; m_stb[i] = 1'b0;
                end else if (mst[i] == 0) begin
                    m_cyc[i] = 1'b0; m_stb[i] = 1'b0;
                end
            end
            begin
                int r = $urandom % 8;
                s_stall = S_STB ? (($urandom % 3) == 0) : 1'($urandom % 2);
                s_rdata = $urandom;
                s_ack = S_CYC ? (r < 3) : (r == 0);
                s_err = S_CYC && r == 3;
            end
            #1;
            if (!busy) begin
                logic [1:0] rq;
                int w;
                rq = m_cyc & m_stb;
                chk("R_idle_cyc", S_CYC, 0);
                if (rq == 2'b00) begin
                    chk("R_stall_none", M_STALL, 2'b11);
                end else begin
                    w = (rq == 2'b11) ? 1 - last : (rq[1] ? 1 : 0);
                    chk("R_stall_win", M_STALL, (w == 0) ? 2'b10 : 2'b01);
                    busy = 1; g = w; stb_ph = 1; cnt = 0; mst[w] = 2;
                end
            end else begin
                chk("R_stall_busy", M_STALL, 2'b11);
                chk("R_busy_cyc", S_CYC, 1);
                chk("R_stb", S_STB, stb_ph);
                if (stb_ph) begin
                    chk("R_s_addr", S_ADDR, ra[g]);
                    chk("R_s_wdata", S_WDATA, rd[g]);
                    chk("R_s_sel", S_SEL, rs[g]);
                    chk("R_s_we", S_WE, rw[g]);
                end
                cnt++;
                if ((s_ack || s_err) && (!stb_ph || !s_stall)) begin
                    exp_ack[g] = s_ack; exp_err[g] = s_err; exp_rd = s_rdata;
                    busy = 0; last = g; mst[g] = 0;
`ifdef WB_ARB_TIMEOUT_EN
                end else if (cnt == T) begin
                    exp_err[g] = 1'b1;
                    busy = 0; last = g; mst[g] = 0;
`endif
                end else if (stb_ph && !s_stall) begin
                    stb_ph = 0;
                end
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
